// File: rtl/sincos_sym_rom.sv
// Quadrature sine/cosine lookup sharing one quarter-wave cosine table through quadrant folding.
// Define SINCOS_ROM_INTERP_EN for linear interpolation on the phase fraction bits (latency 5 instead of 3).
module sincos_sym_rom #(
  parameter int    PHASE_WIDTH    = 16,
  parameter int    ROM_ADDR_WIDTH = 12,
  parameter int    ROM_WIDTH      = 18,
  parameter string ROM_FILE       = "./src/cos_wave_quarter.list"
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic                        in_valid,
  input  logic [PHASE_WIDTH-1:0]      phase,
  output logic                        out_valid,
  output logic signed [ROM_WIDTH-1:0] cos_value,
  output logic signed [ROM_WIDTH-1:0] sin_value
);
  localparam int Q  = 2**(ROM_ADDR_WIDTH-2);
  localparam int IW = ROM_ADDR_WIDTH-1;
  localparam int F  = PHASE_WIDTH-ROM_ADDR_WIDTH;
  localparam int FW = (F > 0) ? F : 1;
  localparam int PW = ROM_WIDTH+F+1;
`ifdef SINCOS_ROM_INTERP_EN
  localparam int NV = 4;
`else
  localparam int NV = 2;
`endif

  // Built-in cosine image.
  function automatic logic [(Q+1)*ROM_WIDTH-1:0] rom_init();
    logic [(Q+1)*ROM_WIDTH-1:0] img;
    real x, term, sum, amp;
    amp = real'(2**(ROM_WIDTH-1) - 1);
    for (int i = 0; i <= Q; i++) begin
      x    = 3.14159265358979323846 * real'(i) / (2.0 * real'(Q));
      term = 1.0;
      sum  = 1.0;
      for (int k = 1; k <= 14; k++) begin
        term = -term * x * x / real'((2*k-1) * (2*k));
        sum  = sum + term;
      end
      img[i*ROM_WIDTH +: ROM_WIDTH] = ROM_WIDTH'($rtoi(sum * amp + 0.5));
    end
    return img;
  endfunction

  logic [(Q+1)*ROM_WIDTH-1:0] rom_image = rom_init();
  logic [ROM_WIDTH-1:0]       rom [0:Q];

  for (genvar gi = 0; gi <= Q; gi++) begin : g_rom
    assign rom[gi] = rom_image[gi*ROM_WIDTH +: ROM_WIDTH];
  end

  logic [ROM_ADDR_WIDTH-1:0]   ch_addr [2];
  logic [FW-1:0]               frac;
  logic [NV-1:0]               vld_reg;
  logic signed [ROM_WIDTH-1:0] res [2];

  assign ch_addr[0] = phase[PHASE_WIDTH-1 -: ROM_ADDR_WIDTH];
  assign ch_addr[1] = phase[PHASE_WIDTH-1 -: ROM_ADDR_WIDTH] - ROM_ADDR_WIDTH'(Q);

  if (F > 0) begin : g_frac
    assign frac = phase[FW-1:0];
  end else begin : g_nofrac
    assign frac = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_reg <= '0;
    else if (ce) vld_reg <= {vld_reg[NV-2:0], in_valid};
  end

`ifdef SINCOS_ROM_INTERP_EN
  logic [FW-1:0] frac1_reg, frac2_reg;
  always_ff @(posedge clk) begin
    if (ce) begin
      frac1_reg <= frac;
      frac2_reg <= frac1_reg;
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^frac;
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [1:0]                quad;
    logic [ROM_ADDR_WIDTH-3:0] low;
    logic [IW-1:0]             idx, idx_reg;
    logic [NV-1:0]             neg_reg;
    logic [ROM_WIDTH-1:0]      rd_reg, mag;

    // Odd quadrants read the table mirrored; quadrants 1 and 2 are negative.
    assign quad = ch_addr[gi][ROM_ADDR_WIDTH-1 -: 2];
    assign low  = ch_addr[gi][ROM_ADDR_WIDTH-3:0];
    assign idx  = quad[0] ? IW'(Q) - IW'(low) : IW'(low);

    always_ff @(posedge clk) begin
      if (ce) begin
        idx_reg <= idx;
        neg_reg <= {neg_reg[NV-2:0], quad[1] ^ quad[0]};
        rd_reg  <= rom[idx_reg];
      end
    end

`ifdef SINCOS_ROM_INTERP_EN
    logic [IW-1:0]         nidx_reg;
    logic [ROM_WIDTH-1:0]  rdn_reg, v0b_reg, y_reg;
    logic signed [PW-1:0]  diff, prod_reg, y_ext;
    logic                  unused_y;

    // Neighbour is the next entry in phase order: +1 unmirrored, -1 mirrored.
    assign diff     = $signed(PW'(rdn_reg)) - $signed(PW'(rd_reg));
    assign unused_y = ^y_ext[PW-1:ROM_WIDTH];

    if (F > 0) begin : g_interp
      localparam logic signed [PW-1:0] RND = PW'(2**(F-1));
      assign y_ext = $signed(PW'(v0b_reg)) + ((prod_reg + RND) >>> F);
    end else begin : g_pass
      assign y_ext = $signed(PW'(v0b_reg));
    end

    always_ff @(posedge clk) begin
      if (ce) begin
        nidx_reg <= quad[0] ? idx - IW'(1) : idx + IW'(1);
        rdn_reg  <= rom[nidx_reg];
        prod_reg <= diff * $signed(PW'(frac2_reg));
        v0b_reg  <= rd_reg;
        y_reg    <= y_ext[ROM_WIDTH-1:0];
      end
    end
    assign mag = y_reg;
`else
    assign mag = rd_reg;
`endif

    assign res[gi] = neg_reg[NV-1] ? -$signed(mag) : $signed(mag);
  end

  // Outputs keep the last valid sample across bubbles and stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      cos_value <= '0;
      sin_value <= '0;
    end else if (ce) begin
      out_valid <= vld_reg[NV-1];
      if (vld_reg[NV-1]) begin
        cos_value <= res[0];
        sin_value <= res[1];
      end
    end
  end

endmodule

// File: tb/tb_sincos_sym_rom.sv
// Randomized self-checking bench for sincos_sym_rom against a trigonometric reference model.
module tb_sincos_sym_rom;
  localparam int  PW    = 16;
  localparam int  AW    = 12;
  localparam int  RW    = 18;
  localparam int  F     = PW - AW;
  localparam int  NADDR = 2**AW;
  localparam int  Q     = NADDR / 4;
  localparam int  AMP   = 2**(RW-1) - 1;
  localparam real PI    = 3.14159265358979323846;
`ifdef SINCOS_ROM_INTERP_EN
  localparam int  LAT   = 5;
`else
  localparam int  LAT   = 3;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 ce = 1'b0;
  logic                 in_valid = 1'b0;
  logic [PW-1:0]        phase = '0;
  logic                 out_valid;
  logic signed [RW-1:0] cos_value, sin_value;

  sincos_sym_rom #(
    .PHASE_WIDTH(PW), .ROM_ADDR_WIDTH(AW), .ROM_WIDTH(RW), .ROM_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .phase(phase),
    .out_valid(out_valid), .cos_value(cos_value), .sin_value(sin_value)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic valid; int cv; int sv; } smp_t;

  smp_t pipe_q[$];
  int   exp_v = 0, exp_c = 0, exp_s = 0;
  int   n_vec = 0, n_err = 0, n_pulse = 0;

  task automatic check(input string tag, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  // Ideal table value at a full-circle address, straight from the trig functions.
  function automatic int wave(input int a, input bit is_sin);
    real ang;
    ang = 2.0 * PI * real'(a % NADDR) / real'(NADDR);
    return rnd(real'(AMP) * (is_sin ? $sin(ang) : $cos(ang)));
  endfunction

  function automatic int ref_val(input logic [PW-1:0] ph, input bit is_sin);
    int a, f, m0, m1, y;
    bit neg;
    a = int'(ph) >> F;
`ifdef SINCOS_ROM_INTERP_EN
    f   = int'(ph) & (2**F - 1);
    m0  = wave(a, is_sin);
    m1  = wave(a + 1, is_sin);
    m0  = (m0 < 0) ? -m0 : m0;
    m1  = (m1 < 0) ? -m1 : m1;
    y   = (F > 0) ? m0 + (((m1 - m0) * f + 2**(F-1)) >>> F) : m0;
    neg = is_sin ? (a >= 2*Q) : (a >= Q && a < 3*Q);
    return neg ? -y : y;
`else
    f = 0; m0 = 0; m1 = 0; y = 0; neg = 1'b0;
    return wave(a, is_sin);
`endif
  endfunction

  task automatic step(input bit r, input bit c, input bit v, input logic [PW-1:0] ph);
    smp_t s;
    @(negedge clk);
    rst = r; ce = c; in_valid = v; phase = ph;
    @(posedge clk);
    if (r) begin
      pipe_q.delete();
      exp_v = 0; exp_c = 0; exp_s = 0;
    end else if (c) begin
      pipe_q.push_back('{valid: v, cv: ref_val(ph, 1'b0), sv: ref_val(ph, 1'b1)});
      if (pipe_q.size() == LAT) begin
        s = pipe_q.pop_front();
        exp_v = int'(s.valid);
        if (s.valid) begin
          exp_c = s.cv;
          exp_s = s.sv;
        end
      end else begin
        exp_v = 0;
      end
    end
    #1;
    check("out_valid", int'(out_valid), exp_v);
    check("cos", int'(cos_value), exp_c);
    check("sin", int'(sin_value), exp_s);
    if (c && !r && out_valid) n_pulse++;
    $display("t=%0t rst=%0d ce=%0d iv=%0d ph=%04h -> ov=%0d cos=%0d sin=%0d",
             $time, r, c, v, ph, out_valid, cos_value, sin_value);
  endtask

  logic [PW-1:0] corners [12] = '{16'h0000, 16'h0008, 16'h3FF8, 16'h3FFF, 16'h4000, 16'h4010,
                                  16'h7FFF, 16'h8000, 16'hBFFF, 16'hC000, 16'hFFF8, 16'hFFFF};

  initial begin
    repeat (3) step(1'b1, 1'b1, 1'b0, '0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_cos", int'(cos_value), 0);

    // phase 0 alone
    step(1'b0, 1'b1, 1'b1, 16'h0000);
    for (int i = 0; i < LAT-1; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("ph0_cos", int'(cos_value), 131071);
    check("ph0_sin", int'(sin_value), 0);

    // three quadrant boundaries back to back
    step(1'b0, 1'b1, 1'b1, 16'h4000);
    step(1'b0, 1'b1, 1'b1, 16'h8000);
    step(1'b0, 1'b1, 1'b1, 16'hC000);
    for (int i = 0; i < LAT-3; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("q1_cos", int'(cos_value), 0);
    check("q1_sin", int'(sin_value), 131071);
    step(1'b0, 1'b1, 1'b0, '0);
    check("q2_cos", int'(cos_value), -131071);
    check("q2_sin", int'(sin_value), 0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("q3_cos", int'(cos_value), 0);
    check("q3_sin", int'(sin_value), -131071);

    // four samples with a two-cycle ce stall after the second
    n_pulse = 0;
    step(1'b0, 1'b1, 1'b1, 16'h1000);
    step(1'b0, 1'b1, 1'b1, 16'h2345);
    step(1'b0, 1'b0, 1'b1, 16'hAAAA);
    step(1'b0, 1'b0, 1'b1, 16'h5555);
    step(1'b0, 1'b1, 1'b1, 16'h9000);
    step(1'b0, 1'b1, 1'b1, 16'hE123);
    for (int i = 0; i < LAT+2; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("stall_pulses", n_pulse, 4);

    // valid, bubble, valid
    step(1'b0, 1'b1, 1'b1, 16'h0800);
    step(1'b0, 1'b1, 1'b0, 16'h7777);
    step(1'b0, 1'b1, 1'b1, 16'hF000);
    for (int i = 0; i < LAT; i++) step(1'b0, 1'b1, 1'b0, '0);

    // reset with two samples in flight
    n_pulse = 0;
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    step(1'b0, 1'b1, 1'b1, 16'h5678);
    step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < LAT+2; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("rst_flush_pulses", n_pulse, 0);

    // randomized traffic with stalls, bubbles and occasional resets
    for (int n = 0; n < 3000; n++) begin
      logic [PW-1:0] ph;
      ph = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 11)] : PW'($urandom);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) != 0, ph);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
